shift_sched: RTL

SHIFT_SCHED -- requirements
Module: shift_sched

---
 rtl/shift_sched_pkg.sv | 13 +
 rtl/shift_sched_rr_arb2.sv | 21 ++
 rtl/shift_sched.sv | 98 +++++++++
 3 files changed

// File: rtl/shift_sched_pkg.sv
// shift_sched_pkg: defaults and encodings shared by the shift scheduler and its arbiter
package shift_sched_pkg;
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_AMT_W   = 5;
    localparam int DEF_LATENCY = 5;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;
    typedef struct packed {
        logic  valid;
        port_e port;
    } tag_t;
endpackage

// File: rtl/shift_sched_rr_arb2.sv
// rr_arb2: two-way round-robin grant; pointer names the port favoured on the next contention
module rr_arb2
    import shift_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       hold,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    port_e pri_q, pri_d;

    always_comb begin
        gnt = 2'b00;
        if (!reset && !hold)
            gnt = (req == 2'b11) ? ((pri_q == PORT1) ? 2'b10 : 2'b01) : req;
        pri_d = gnt[0] ? PORT1 : gnt[1] ? PORT0 : pri_q;
    end

    always_ff @(posedge clk) pri_q <= reset ? PORT0 : pri_d;
endmodule

// File: rtl/shift_sched.sv
// shift_sched: arbitrates two requesters onto one pipelined shifter and routes results back by tag
module shift_sched
    import shift_sched_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int AMT_W   = DEF_AMT_W,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic             req0_dir,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [AMT_W-1:0] req1_amt,
    input  logic             req1_dir,
    output logic             sh_valid,
    output logic [WIDTH-1:0] sh_data,
    output logic [AMT_W-1:0] sh_amt,
    output logic             sh_dir,
    input  logic [WIDTH-1:0] sh_result,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);
    logic [1:0] gnt;
    logic sh_valid_q, sh_valid_d;
    port_e sh_port_q, sh_port_d;
    logic [WIDTH-1:0] sh_data_q, sh_data_d;
    logic [AMT_W-1:0] sh_amt_q, sh_amt_d;
    logic sh_dir_q, sh_dir_d;
    tag_t [LATENCY-1:0] tag_q, tag_d;
    tag_t rsp_q, rsp_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic tag_busy;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .hold  (hold),
        .req   ({req1_valid, req0_valid}),
        .gnt   (gnt)
    );

    always_comb begin
        sh_valid_d = |gnt;
        sh_port_d  = gnt[1] ? PORT1 : PORT0;
        sh_data_d  = gnt[1] ? req1_data : gnt[0] ? req0_data : sh_data_q;
        sh_amt_d   = gnt[1] ? req1_amt  : gnt[0] ? req0_amt  : sh_amt_q;
        sh_dir_d   = gnt[1] ? req1_dir  : gnt[0] ? req0_dir  : sh_dir_q;
        // tag chain tracks the shifter pipeline so the last stage lines up with sh_result
        tag_d[0] = tag_t'{valid: sh_valid_q, port: sh_port_q};
        for (int i = 1; i < LATENCY; i++) tag_d[i] = tag_q[i-1];
        rsp_d      = tag_q[LATENCY-1];
        rsp_data_d = sh_result;
        tag_busy   = 1'b0;
        for (int i = 0; i < LATENCY; i++) tag_busy = tag_busy | tag_q[i].valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_valid_q <= 1'b0;
            sh_port_q  <= PORT0;
            sh_data_q  <= '0;
            sh_amt_q   <= '0;
            sh_dir_q   <= 1'b0;
            tag_q      <= '0;
            rsp_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            sh_valid_q <= sh_valid_d;
            sh_port_q  <= sh_port_d;
            sh_data_q  <= sh_data_d;
            sh_amt_q   <= sh_amt_d;
            sh_dir_q   <= sh_dir_d;
            tag_q      <= tag_d;
            rsp_q      <= rsp_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign sh_valid   = sh_valid_q & ~reset;
    assign sh_data    = sh_data_q;
    assign sh_amt     = sh_amt_q;
    assign sh_dir     = sh_dir_q;
    assign rsp0_valid = rsp_q.valid & (rsp_q.port == PORT0) & ~reset;
    assign rsp1_valid = rsp_q.valid & (rsp_q.port == PORT1) & ~reset;
    assign rsp_data   = rsp_data_q;
    assign busy       = ~reset & (sh_valid_q | tag_busy | rsp_q.valid);
endmodule
